// File: rtl/iob_split_dec_pkg.sv
// Shared definitions for the address-decoding IOb splitter: FSM state
// encoding and helpers that give the packed request/response field offsets
// and derived widths for a given parameterisation.
package iob_split_dec_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2,
        S_RESP = 2'd3
    } splitStateT;

    // Request is packed {valid, addr, wdata, wstrb}
    function automatic int reqWidth(input int addrW, input int dataW);
        return 1 + addrW + dataW + dataW / 8;
    endfunction

    // Response is packed {rdata, ready}
    function automatic int respWidth(input int dataW);
        return dataW + 1;
    endfunction

    function automatic int wstrbOff();
        return 0;
    endfunction

    function automatic int wdataOff(input int dataW);
        return dataW / 8;
    endfunction

    function automatic int addrOff(input int dataW);
        return dataW + dataW / 8;
    endfunction

    function automatic int validOff(input int addrW, input int dataW);
        return addrW + dataW + dataW / 8;
    endfunction

    function automatic int readyOff();
        return 0;
    endfunction

    function automatic int rdataOff();
        return 1;
    endfunction

    // Wait counter must hold values 0..timeout; a disabled timeout still needs one bit
    function automatic int cntWidth(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    // Slave index width, never narrower than one bit
    function automatic int selWidth(input int nSlaves);
        return (nSlaves < 2) ? 1 : $clog2(nSlaves);
    endfunction

endpackage

// File: rtl/iob_split_dec_addr_dec.sv
// Combinational priority address decoder: reports whether any slave window
// matches the address and, if several do, selects the lowest-index one.
module iob_addr_dec
    import iob_split_dec_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int N_SLAVES = 4,
    parameter int SEL_W    = selWidth(N_SLAVES)
) (
    input  logic [ADDR_W-1:0]          addr_i,
    input  logic [N_SLAVES*ADDR_W-1:0] base_i,
    input  logic [N_SLAVES*ADDR_W-1:0] mask_i,
    output logic                       hit_o,
    output logic [SEL_W-1:0]           sel_o
);

    // Scan from the top so the lowest matching index is the last one written
    always_comb begin
        hit_o = 1'b0;
        sel_o = '0;
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if ((addr_i & mask_i[k*ADDR_W +: ADDR_W]) ==
                (base_i[k*ADDR_W +: ADDR_W] & mask_i[k*ADDR_W +: ADDR_W])) begin
                hit_o = 1'b1;
                sel_o = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/iob_split_dec.sv
// IOb native-bus splitter routing one master to N_SLAVES slaves by base/mask
// match. Request and response are registered; unmapped accesses and slave
// timeouts complete with ERR_DATA and are logged in the error status outputs.
module iob_split_dec
    import iob_split_dec_pkg::*;
#(
    parameter int                         ADDR_W   = 32,
    parameter int                         DATA_W   = 32,
    parameter int                         N_SLAVES = 4,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK = '0,
    parameter int                         TIMEOUT  = 255,
    parameter logic [31:0]                ERR_DATA = 32'hDEADBEEF,
    localparam int                        REQ_W    = reqWidth(ADDR_W, DATA_W),
    localparam int                        RESP_W   = respWidth(DATA_W)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQ_W-1:0]           m_req,
    output logic [RESP_W-1:0]          m_resp,
    output logic [N_SLAVES*REQ_W-1:0]  s_req,
    input  logic [N_SLAVES*RESP_W-1:0] s_resp,
    output logic                       err,
    output logic [ADDR_W-1:0]          err_addr,
    output logic [15:0]                err_cnt
);

    localparam int                STRB_W    = DATA_W / 8;
    localparam int                SEL_W     = selWidth(N_SLAVES);
    localparam int                CNT_W     = cntWidth(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT);
    localparam logic [DATA_W-1:0] ERR_RDATA = DATA_W'(ERR_DATA);

    splitStateT        state_q, state_d;
    logic [SEL_W-1:0]  sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic              respErr_q;
    logic [ADDR_W-1:0] errAddr_q;
    logic [15:0]       errCnt_q;

    logic              mValid;
    logic [ADDR_W-1:0] mAddr;
    logic [DATA_W-1:0] mWdata;
    logic [STRB_W-1:0] mWstrb;
    logic              decHit;
    logic [SEL_W-1:0]  decSel;
    logic              selReady;
    logic [DATA_W-1:0] selRdata;
    logic              timeoutHit;
    logic              logErr;

    assign mValid = m_req[validOff(ADDR_W, DATA_W)];
    assign mAddr  = m_req[addrOff(DATA_W) +: ADDR_W];
    assign mWdata = m_req[wdataOff(DATA_W) +: DATA_W];
    assign mWstrb = m_req[wstrbOff() +: STRB_W];

    assign timeoutHit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    assign logErr     = (state_q == S_ERR) ||
                        ((state_q == S_WAIT) && !selReady && timeoutHit);

    iob_addr_dec #(
        .ADDR_W  (ADDR_W),
        .N_SLAVES(N_SLAVES),
        .SEL_W   (SEL_W)
    ) u_addr_dec (
        .addr_i(mAddr),
        .base_i(SLV_BASE),
        .mask_i(SLV_MASK),
        .hit_o (decHit),
        .sel_o (decSel)
    );

    // Pick out ready/rdata of the selected slave only; all others are ignored
    always_comb begin
        selReady = 1'b0;
        selRdata = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (sel_q == SEL_W'(k)) begin
                selReady = s_resp[k*RESP_W + readyOff()];
                selRdata = s_resp[k*RESP_W + rdataOff() +: DATA_W];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a slave ready seen together with the timeout wins over the abort
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (mValid) begin
                    state_d = decHit ? S_WAIT : S_ERR;
                end
            end
            S_WAIT: begin
                if (selReady || timeoutHit) begin
                    state_d = S_RESP;
                end
            end
            S_ERR:   state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Transaction datapath: latch the request, count wait cycles, capture response data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            respErr_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mValid) begin
                        addr_q  <= mAddr;
                        wdata_q <= mWdata;
                        wstrb_q <= mWstrb;
                        cnt_q   <= '0;
                        if (decHit) begin
                            sel_q <= decSel;
                        end
                    end
                end
                S_WAIT: begin
                    if (selReady) begin
                        rdata_q   <= selRdata;
                        respErr_q <= 1'b0;
                    end else if (timeoutHit) begin
                        rdata_q   <= ERR_RDATA;
                        respErr_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_ERR: begin
                    rdata_q   <= ERR_RDATA;
                    respErr_q <= 1'b1;
                end
                default: begin
                    respErr_q <= 1'b0;
                end
            endcase
        end
    end

    // Error log is written on entry to RESP so it is already visible during the err pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            errAddr_q <= '0;
            errCnt_q  <= '0;
        end else if (logErr) begin
            errAddr_q <= addr_q;
            if (errCnt_q != 16'hFFFF) begin
                errCnt_q <= errCnt_q + 16'd1;
            end
        end
    end

    // Outputs decoded from registered state; request fields broadcast, valid only to sel
    always_comb begin
        s_req = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            s_req[k*REQ_W +: REQ_W] = {(state_q == S_WAIT) && (sel_q == SEL_W'(k)),
                                       addr_q, wdata_q, wstrb_q};
        end
        m_resp = '0;
        if (state_q == S_RESP) begin
            m_resp = {rdata_q, 1'b1};
        end
        err      = (state_q == S_RESP) && respErr_q;
        err_addr = errAddr_q;
        err_cnt  = errCnt_q;
    end

endmodule
